fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 output_pc  in  32  current PC from pc block.
REQ-005 new_addr  out  32  next PC value to pc block.
REQ-006 pc_en  out  1  pc load enable, one-cycle pulse.
REQ-007 imem_req  out  1  instruction memory read request.
REQ-008 imem_addr  out  32  read address, equals output_pc.
REQ-009 imem_ack  in  1  read complete, imem_rdata valid this cycle.
REQ-010 imem_rdata  in  32  instruction word.
REQ-011 redirect_valid  in  1  branch/jump/flush from later stage.
REQ-012 redirect_addr  in  32  redirect target.
REQ-013 id_valid  out  1  instruction available to decode.
REQ-014 id_ready  in  1  decode accepts.
REQ-015 id_instr  out  32  held instruction.
REQ-016 id_pc  out  32  PC of held instruction.

Function
REQ-017 FSM states BOOT, IDLE, REQ, DROP, HOLD; one-hot or binary at implementer's choice.
REQ-018 BOOT: pc_en=1, new_addr=RESET_PC; next state IDLE unconditionally.
REQ-019 IDLE: imem_req=0, pc_en=0; next state REQ (one-cycle bubble for PC update).
REQ-020 REQ: imem_req=1; on imem_ack with no redirect, register imem_rdata->id_instr, output_pc->id_pc, go HOLD.
REQ-021 REQ with redirect_valid and no imem_ack: latch redirect_addr into pending register, go DROP; imem_req stays 1.
REQ-022 REQ with redirect_valid and imem_ack same cycle: discard data, pc_en=1, new_addr=redirect_addr, go IDLE.
REQ-023 DROP: imem_req=1 until imem_ack; new redirect_valid overwrites pending; on imem_ack discard data, pc_en=1, new_addr=pending (or redirect_addr if redirect_valid same cycle), go IDLE.
REQ-024 HOLD: id_valid=1, id_instr/id_pc stable; on id_valid&&id_ready: pc_en=1, new_addr=output_pc+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), go IDLE.
REQ-025 HOLD with redirect_valid: id_valid forced 0 combinationally that cycle (no transfer), pc_en=1, new_addr=redirect_addr, go IDLE.
REQ-026 id_valid=0 in every state except HOLD.
REQ-027 pc_en, new_addr, imem_req, imem_addr, id_valid combinational from state/inputs; id_instr, id_pc, pending registered.
REQ-028 new_addr=output_pc whenever pc_en=0.
REQ-029 imem_addr never changes while imem_req=1 (guaranteed since pc_en=0 in REQ/DROP except ack cycle).
REQ-030 redirect_valid in BOOT ignored; in IDLE: pc_en=1, new_addr=redirect_addr, stay IDLE one more cycle.

Reset
REQ-031 While rst=1: state BOOT next, pc_en=0, imem_req=0, id_valid=0, id_instr=0, id_pc=0, pending=0, new_addr=RESET_PC.
REQ-032 rst asserted mid-transaction abandons it; late imem_ack ignored in BOOT/IDLE.

Configuration
REQ-033 Macro FETCH_CTRL_STAT_EN: when defined, adds outputs fetch_cnt[31:0] (increments per id_valid&&id_ready) and stall_cnt[31:0] (increments per cycle in REQ or DROP without imem_ack), both wrap, cleared by rst; when undefined, ports and logic absent, all other behaviour identical.

Verification
REQ-034 RESET_PC=0x100, rst released, imem_ack tied 1, id_ready=1 -> cycle0 pc_en=1/new_addr=0x100, cycle2 imem_addr=0x100, cycle3 id_valid/id_pc=0x100, next fetch 0x104 at cycle5.
REQ-035 imem_ack delayed 4 cycles in REQ -> imem_req and imem_addr held stable 4 cycles, id_instr=imem_rdata of ack cycle.
REQ-036 redirect_valid addr 0x200 in REQ, ack 2 cycles later -> data discarded, id_valid never asserted for it, pc_en with new_addr=0x200, next imem_addr=0x200.
REQ-037 HOLD with id_ready=0 three cycles then redirect 0x40 with id_ready=1 -> id_valid 0 that cycle, no transfer, new_addr=0x40.
REQ-038 output_pc=0xFFFF_FFFC accepted -> new_addr=0x0000_0000.
REQ-039 rst pulsed in DROP with ack next cycle -> ack ignored, restart from RESET_PC; with FETCH_CTRL_STAT_EN, counters read 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC updates, issues imem reads, holds fetched word for decode.
// Latency: BOOT->IDLE->REQ, then one cycle per imem_ack; the fetched word is presented the cycle after ack.
// Backpressure: word held in HOLD until id_ready or redirect; optional FETCH_CTRL_STAT_EN adds fetch/stall counters.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] output_pc,
   output logic [31:0] new_addr,
   output logic        pc_en,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_addr,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
`ifdef FETCH_CTRL_STAT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] stall_cnt
`endif
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_IDLE,
      S_REQ,
      S_DROP,
      S_HOLD
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pending;
   logic        capture;
   logic        load_pending;

   assign imem_addr = output_pc;

   always_comb begin
      state_nxt    = state;
      pc_en        = 1'b0;
      new_addr     = output_pc;
      imem_req     = 1'b0;
      id_valid     = 1'b0;
      capture      = 1'b0;
      load_pending = 1'b0;
      if (rst) begin
         new_addr  = RESET_PC;
         state_nxt = S_BOOT;
      end else begin
         case (state)
            S_BOOT: begin
               pc_en     = 1'b1;
               new_addr  = RESET_PC;
               state_nxt = S_IDLE;
            end
            S_IDLE: begin
               // A redirect here costs one more bubble so the PC block can settle.
               if (redirect_valid) begin
                  pc_en    = 1'b1;
                  new_addr = redirect_addr;
               end else begin
                  state_nxt = S_REQ;
               end
            end
            S_REQ: begin
               imem_req = 1'b1;
               if (imem_ack && redirect_valid) begin
                  pc_en     = 1'b1;
                  new_addr  = redirect_addr;
                  state_nxt = S_IDLE;
               end else if (imem_ack) begin
                  capture   = 1'b1;
                  state_nxt = S_HOLD;
               end else if (redirect_valid) begin
                  load_pending = 1'b1;
                  state_nxt    = S_DROP;
               end
            end
            S_DROP: begin
               // The in-flight read must complete before the PC may move.
               imem_req = 1'b1;
               if (imem_ack) begin
                  pc_en     = 1'b1;
                  new_addr  = redirect_valid ? redirect_addr : pending;
                  state_nxt = S_IDLE;
               end else if (redirect_valid) begin
                  load_pending = 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  pc_en     = 1'b1;
                  new_addr  = redirect_addr;
                  state_nxt = S_IDLE;
               end else begin
                  id_valid = 1'b1;
                  if (id_ready) begin
                     pc_en     = 1'b1;
                     new_addr  = output_pc + 32'd4;
                     state_nxt = S_IDLE;
                  end
               end
            end
            default: state_nxt = S_BOOT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_BOOT;
         id_instr <= 32'd0;
         id_pc    <= 32'd0;
         pending  <= 32'd0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            id_instr <= imem_rdata;
            id_pc    <= output_pc;
         end
         if (load_pending) pending <= redirect_addr;
      end
   end

`ifdef FETCH_CTRL_STAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= 32'd0;
         stall_cnt <= 32'd0;
      end else begin
         if (id_valid && id_ready) fetch_cnt <= fetch_cnt + 32'd1;
         if ((state == S_REQ || state == S_DROP) && !imem_ack) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed sequences then random traffic against a PC-stream reference model.
module tb_fetch_ctrl;
   localparam logic [31:0] RPC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] output_pc = 32'd0;
   logic [31:0] new_addr;
   logic        pc_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_addr = 32'd0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
`ifdef FETCH_CTRL_STAT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
`endif

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   logic        prev_rst = 1'b1;
   logic        boot;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst), .output_pc(output_pc), .new_addr(new_addr), .pc_en(pc_en),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .id_valid(id_valid),
      .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
`ifdef FETCH_CTRL_STAT_EN
      , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
   );

   // External PC register the controller steers.
   always @(posedge clk) if (pc_en) output_pc <= new_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; the reference model learns the next expected fetch PC here.
   task automatic step(input logic r, input logic a, input logic y, input logic v, input logic [31:0] ra);
      @(posedge clk);
      #1;
      rst            = r;
      imem_ack       = a;
      id_ready       = y;
      imem_rdata     = a ? mem_word(output_pc) : 32'($urandom);
      boot           = prev_rst && !r;
      redirect_valid = v && !r && !boot;
      redirect_addr  = ra;
      if (r) begin
         exp_q.delete();
         exp_q.push_back(RPC);
      end else if (redirect_valid) begin
         exp_q.delete();
         exp_q.push_back(ra);
      end
      prev_rst = r;
      @(negedge clk);
   endtask

   // Monitor: every decode transfer must carry the next PC of the architectural stream.
   initial begin
      logic [31:0] e;
      logic        m_req = 1'b0;
      logic        m_ack = 1'b0;
      logic        m_rst = 1'b1;
      logic [31:0] m_addr = 32'd0;
      int          stall = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (id_valid && id_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL xfer_unexpected: id_pc %h with no expected fetch", id_pc);
               end else begin
                  e = exp_q.pop_front();
                  chk("xfer_pc", id_pc, e);
                  chk("xfer_instr", id_instr, mem_word(e));
                  exp_q.push_back(e + 32'd4);
               end
               stall = 0;
            end else begin
               stall++;
            end
            if (!pc_en) chk("new_addr_when_idle", new_addr, output_pc);
            if (m_req && !m_ack && !m_rst && imem_req) chk("imem_addr_stable", imem_addr, m_addr);
            if (stall > 200) begin
               checks++;
               errors++;
               $display("FAIL watchdog: no decode transfer for %0d cycles, required <= 200", stall);
               stall = 0;
            end
         end else begin
            stall = 0;
         end
         m_req  = imem_req;
         m_ack  = imem_ack;
         m_rst  = rst;
         m_addr = imem_addr;
      end
   end

   initial begin
      logic [31:0] tmp;
      logic [31:0] ra;
      repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("rst_pc_en", pc_en, 0);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_instr", id_instr, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_new_addr", new_addr, RPC);

      // Back-to-back fetch with ack tied high and decode always ready.
      step(0, 1, 1, 0, 0);  chk("boot_pc_en", pc_en, 1); chk("boot_new_addr", new_addr, RPC);
      step(0, 1, 1, 0, 0);  chk("idle_req", imem_req, 0);
      step(0, 1, 1, 0, 0);  chk("req_req", imem_req, 1); chk("req_addr", imem_addr, RPC);
      step(0, 1, 1, 0, 0);  chk("hold_valid", id_valid, 1); chk("hold_pc", id_pc, RPC);
      step(0, 1, 1, 0, 0);
      // Ack delayed four cycles.
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 0, 0);
         chk("stall_req", imem_req, 1);
         chk("stall_addr", imem_addr, RPC + 32'd4);
      end
      step(0, 1, 0, 0, 0);
      // Decode stalls three cycles, then a redirect cancels the held word.
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0);
         chk("held_valid", id_valid, 1);
         chk("held_pc", id_pc, RPC + 32'd4);
         chk("held_instr", id_instr, mem_word(RPC + 32'd4));
      end
      step(0, 0, 1, 1, 32'h40); chk("hold_redir_valid", id_valid, 0);
      chk("hold_redir_pc_en", pc_en, 1); chk("hold_redir_addr", new_addr, 32'h40);
      step(0, 0, 1, 0, 0);
      // Redirect during an outstanding read, ack two cycles later.
      step(0, 0, 1, 1, 32'h200); chk("drop_entry_addr", imem_addr, 32'h40);
      step(0, 0, 1, 0, 0);       chk("drop_req", imem_req, 1); chk("drop_addr", imem_addr, 32'h40);
      step(0, 1, 1, 0, 0);       chk("drop_ack_pc_en", pc_en, 1);
      chk("drop_ack_addr", new_addr, 32'h200); chk("drop_ack_valid", id_valid, 0);
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);       chk("post_drop_addr", imem_addr, 32'h200);
      step(0, 0, 1, 0, 0);       chk("post_drop_pc", id_pc, 32'h200);
      // Redirect in IDLE to the top of the address space, then wrap.
      step(0, 0, 1, 1, 32'hFFFF_FFFC); chk("idle_redir_addr", new_addr, 32'hFFFF_FFFC);
      step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 0, 1, 0, 0);       chk("wrap_pc_en", pc_en, 1); chk("wrap_addr", new_addr, 32'd0);
      step(0, 0, 1, 0, 0);
      // Reset pulse while a dropped read is outstanding; the late ack must be ignored.
      step(0, 0, 1, 1, 32'h300); chk("wrap_fetch_addr", imem_addr, 32'd0);
      step(1, 0, 1, 0, 0);       chk("mid_rst_pc_en", pc_en, 0); chk("mid_rst_req", imem_req, 0);
      step(0, 1, 1, 0, 0);       chk("late_ack_boot_addr", new_addr, RPC); chk("late_ack_pc_en", pc_en, 1);
`ifdef FETCH_CTRL_STAT_EN
      chk("fetch_cnt_cleared", fetch_cnt, 0);
      chk("stall_cnt_cleared", stall_cnt, 0);
`endif
      step(0, 1, 1, 0, 0);       chk("late_ack_idle_req", imem_req, 0); chk("late_ack_idle_pc_en", pc_en, 0);
      step(0, 1, 1, 0, 0);       chk("restart_addr", imem_addr, RPC);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         tmp = $urandom;
         ra  = {tmp[31:2], 2'b00};
         if ($urandom_range(0, 7) == 0) ra = 32'hFFFF_FFFC;
         step(($urandom_range(0, 599) == 0), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 11) == 0), ra);
      end
      repeat (5) step(0, 1, 1, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
